// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared definitions for the matrix-multiply datapath (index generator and
// MAC accumulator): the controller state encoding and width helpers used to
// size index and accumulator ports from the matrix dimensions.
// -----------------------------------------------------------------------------
package matrix_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2,
        DONE   = 2'd3
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Wide enough to hold any of i, j, k and their upper bounds.
    function automatic int idx_width(input int rows, input int cols, input int inner);
        return $clog2(max3(rows, cols, inner) + 1);
    endfunction

    // Full product width plus headroom for summing 'inner' products.
    function automatic int acc_width(input int width_bit, input int inner);
        return 2 * width_bit + $clog2(inner + 1);
    endfunction

endpackage

// File: rtl/matrix_mac_accumulator_mac_unit.sv
// -----------------------------------------------------------------------------
// mac_unit
// Signed multiplier feeding an accumulator register.
//   clock_i       rising-edge clock
//   nreset_i      asynchronous active-low reset, clears the accumulator
//   clear_first_i the current pair starts a new sum (previous total ignored)
//   enable_i      an operand pair is being accepted this cycle
//   a_i, b_i      signed operands
//   acc_o         running sum including the current pair (combinational);
//                 the owner registers it when the final pair is accepted
// -----------------------------------------------------------------------------
module mac_unit #(
    parameter int WIDTH_BIT = 32,
    parameter int ACC_WIDTH = 66
) (
    input  logic                        clock_i,
    input  logic                        nreset_i,
    input  logic                        clear_first_i,
    input  logic                        enable_i,
    input  logic signed [WIDTH_BIT-1:0] a_i,
    input  logic signed [WIDTH_BIT-1:0] b_i,
    output logic        [ACC_WIDTH-1:0] acc_o
);

    logic signed [2*WIDTH_BIT-1:0] prod;
    logic        [ACC_WIDTH-1:0]   prod_ext;
    logic        [ACC_WIDTH-1:0]   acc_q;

    assign prod     = a_i * b_i;
    // Cast of a signed operand sign-extends into the accumulator width.
    assign prod_ext = ACC_WIDTH'(prod);
    assign acc_o    = (clear_first_i ? '0 : acc_q) + prod_ext;

    always_ff @(posedge clock_i or negedge nreset_i) begin
        if (!nreset_i) begin
            acc_q <= '0;
        end else if (enable_i) begin
            acc_q <= acc_o;
        end
    end

endmodule

// File: rtl/matrix_mac_accumulator.sv
// -----------------------------------------------------------------------------
// matrix_mac_accumulator
// Consumes the A[i][k]/B[k][j] operand stream (k fastest), accumulates each
// run of ACOLUMNS pairs and emits C[i][j] tagged with its row and column.
//   clock, nreset           clock, asynchronous active-low reset
//   start                   begin a new product (only honoured in IDLE)
//   in_valid/in_ready       operand pair handshake; a_data, b_data signed
//   out_valid/out_ready     result handshake; out_data, out_row, out_col
//   busy                    high in every state but IDLE
//   done                    one-cycle pulse after the last result is taken
//
// state  | meaning
// IDLE   | waiting for start
// ACCUM  | accepting operand pairs for the current C[i][j]
// OUTPUT | holding a result until out_ready
// DONE   | final result taken, pulse done then return to IDLE
// -----------------------------------------------------------------------------
module matrix_mac_accumulator
    import matrix_pkg::*;
#(
    parameter int AROWS     = 3,
    parameter int ACOLUMNS  = 3,
    parameter int BCOLUMNS  = 3,
    parameter int WIDTH_BIT = 32,
    parameter int ACC_WIDTH = acc_width(WIDTH_BIT, ACOLUMNS),
    parameter int IDX_WIDTH = idx_width(AROWS, BCOLUMNS, ACOLUMNS)
) (
    input  logic                 clock,
    input  logic                 nreset,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH_BIT-1:0] a_data,
    input  logic [WIDTH_BIT-1:0] b_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic [IDX_WIDTH-1:0] out_row,
    output logic [IDX_WIDTH-1:0] out_col,
    output logic                 busy,
    output logic                 done
);

    localparam logic [IDX_WIDTH-1:0] K_LAST = IDX_WIDTH'(ACOLUMNS - 1);
    localparam logic [IDX_WIDTH-1:0] J_LAST = IDX_WIDTH'(BCOLUMNS - 1);
    localparam logic [IDX_WIDTH-1:0] I_LAST = IDX_WIDTH'(AROWS - 1);
    localparam logic [IDX_WIDTH-1:0] IDX_ONE = IDX_WIDTH'(1);

    state_e               state_q;
    logic [IDX_WIDTH-1:0] i_q, j_q, k_q;
    logic                 in_ready_q, out_valid_q, busy_q, done_q;
    logic [ACC_WIDTH-1:0] out_data_q;
    logic [IDX_WIDTH-1:0] out_row_q, out_col_q;

    logic                 xfer;
    logic                 out_fire;
    logic [ACC_WIDTH-1:0] sum;

    // in_ready_q is only ever high in ACCUM, so it also gates consumption.
    assign xfer     = in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;

    mac_unit #(
        .WIDTH_BIT (WIDTH_BIT),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .clock_i       (clock),
        .nreset_i      (nreset),
        .clear_first_i (k_q == '0),
        .enable_i      (xfer),
        .a_i           (a_data),
        .b_i           (b_data),
        .acc_o         (sum)
    );

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q     <= IDLE;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        i_q        <= '0;
                        j_q        <= '0;
                        k_q        <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        if (k_q == K_LAST) begin
                            k_q         <= '0;
                            out_data_q  <= sum;
                            out_row_q   <= i_q;
                            out_col_q   <= j_q;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= OUTPUT;
                        end else begin
                            k_q <= k_q + IDX_ONE;
                        end
                    end
                end
                OUTPUT: begin
                    if (out_fire) begin
                        out_valid_q <= 1'b0;
                        if (j_q != J_LAST) begin
                            j_q        <= j_q + IDX_ONE;
                            in_ready_q <= 1'b1;
                            state_q    <= ACCUM;
                        end else if (i_q != I_LAST) begin
                            j_q        <= '0;
                            i_q        <= i_q + IDX_ONE;
                            in_ready_q <= 1'b1;
                            state_q    <= ACCUM;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
